// File: rtl/rob_pkg.sv
// Shared defaults, entry layout and the wrap-aware age compare for the reorder buffer.
package rob_pkg;

  localparam int ROB_DEPTH  = 64;
  localparam int ROB_NW     = 4;
  localparam int ROB_NWB    = 4;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_PC_W   = 64;
  localparam int ROB_PREG_W = 8;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  exc;
    logic [ROB_PC_W-1:0]   pc;
    logic [ROB_PREG_W-1:0] rd;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  // True when tag lies in [lo, hi) measured modulo 2^tag_w, so the wrap bit orders ages.
  function automatic logic tag_in_window(input logic [31:0] tag, input logic [31:0] lo,
                                         input logic [31:0] hi, input int unsigned tag_w);
    logic [31:0] mask;
    mask = (32'd1 << tag_w) - 32'd1;
    return ((tag - lo) & mask) < ((hi - lo) & mask);
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks the in-order retiring lanes from the head window and flags an exception at head.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int NW    = ROB_NW,
  parameter int CNT_W = 7
) (
  input  logic             enable,
  input  logic [CNT_W-1:0] avail,
  input  logic [NW-1:0]    win_valid,
  input  logic [NW-1:0]    win_done,
  input  logic [NW-1:0]    win_exc,
  output logic [NW-1:0]    commit_mask,
  output logic             head_exc
);

  assign head_exc = win_valid[0] && win_done[0] && win_exc[0];

  always_comb begin : sel
    logic ok;
    ok = enable;
    commit_mask = '0;
    for (int k = 0; k < NW; k++) begin
      ok = ok && win_valid[k] && win_done[k] && !win_exc[k] && (CNT_W'(k) < avail);
      commit_mask[k] = ok;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane allocate/commit, writeback filtering, mispredict squash
// and exception flush.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int NW     = ROB_NW,
  parameter int NWB    = ROB_NWB,
  parameter int DATA_W = ROB_DATA_W,
  parameter int PC_W   = ROB_PC_W,
  parameter int PREG_W = ROB_PREG_W,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = IDX_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stop,
  input  logic [NW-1:0]       alloc_valid,
  input  logic [NW*PC_W-1:0]  alloc_pc,
  input  logic [NW*PREG_W-1:0] alloc_rd,
  output logic                alloc_ready,
  output logic [NW*TAG_W-1:0] alloc_tag,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*DATA_W-1:0] wb_data,
  input  logic [NWB-1:0]      wb_exc,
  output logic [NW-1:0]       commit_valid,
  output logic [NW*TAG_W-1:0] commit_tag,
  output logic [NW*PC_W-1:0]  commit_pc,
  output logic [NW*PREG_W-1:0] commit_rd,
  output logic [NW*DATA_W-1:0] commit_data,
  input  logic                bp_mispredict,
  input  logic [TAG_W-1:0]    bp_tag,
  output logic                flush_valid,
  output logic [PC_W-1:0]     flush_pc,
  output logic [IDX_W:0]      count,
  output logic                full,
  output logic                empty
);

  logic [TAG_W-1:0]  head, tail, used, commit_avail, n_alloc, n_commit, bp_next;
  logic [DEPTH-1:0]  ent_valid, ent_done, ent_exc, squash, commit_clr, alloc_set;
  logic [PC_W-1:0]   ent_pc   [DEPTH];
  logic [PREG_W-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [NW-1:0]     win_valid, win_done, win_exc, commit_mask;
  logic [NWB-1:0]    wb_hit;
  logic              head_exc, flush_take, bp_hit, alloc_fire, commit_en;

  function automatic logic in_win(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] lo,
                                  input logic [TAG_W-1:0] hi);
    return tag_in_window(32'(t), 32'(lo), 32'(hi), TAG_W);
  endfunction

  assign used         = tail - head;
  assign count        = used;
  assign full         = (used == TAG_W'(DEPTH));
  assign empty        = (used == '0);
  assign bp_next      = bp_tag + TAG_W'(1);
  assign bp_hit       = bp_mispredict && in_win(bp_tag, head, tail);
  assign alloc_ready  = !stop && !bp_mispredict && !flush_valid &&
                        ((TAG_W'(DEPTH) - used) >= TAG_W'(NW));
  assign alloc_fire   = alloc_ready && (|alloc_valid);
  assign flush_take   = head_exc && !flush_valid;
  assign commit_en    = !stop && !flush_valid;
  // During a mispredict only entries up to and including bp_tag may retire.
  assign commit_avail = bp_hit ? (bp_next - head) : used;
  assign commit_valid = commit_mask;

  for (genvar k = 0; k < NW; k++) begin : g_win
    logic [TAG_W-1:0] t;
    assign t = head + TAG_W'(k);
    assign win_valid[k] = ent_valid[t[IDX_W-1:0]];
    assign win_done[k]  = ent_done[t[IDX_W-1:0]];
    assign win_exc[k]   = ent_exc[t[IDX_W-1:0]];
    assign commit_tag[k*TAG_W +: TAG_W]    = t;
    assign commit_pc[k*PC_W +: PC_W]       = ent_pc[t[IDX_W-1:0]];
    assign commit_rd[k*PREG_W +: PREG_W]   = ent_rd[t[IDX_W-1:0]];
    assign commit_data[k*DATA_W +: DATA_W] = ent_data[t[IDX_W-1:0]];
    assign alloc_tag[k*TAG_W +: TAG_W]     = tail + TAG_W'(k);
  end

  for (genvar p = 0; p < NWB; p++) begin : g_wb
    logic [TAG_W-1:0] wt;
    assign wt = wb_tag[p*TAG_W +: TAG_W];
    assign wb_hit[p] = wb_valid[p] && in_win(wt, head, tail) && ent_valid[wt[IDX_W-1:0]] &&
                       !(bp_hit && !in_win(wt, head, bp_next));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_sq
    logic [IDX_W-1:0] off;
    logic [TAG_W-1:0] ti;
    assign off = IDX_W'(i) - head[IDX_W-1:0];
    assign ti  = head + {1'b0, off};
    assign squash[i] = bp_hit && in_win(ti, bp_next, tail);
  end

  always_comb begin
    n_alloc    = '0;
    n_commit   = '0;
    commit_clr = '0;
    alloc_set  = '0;
    for (int k = 0; k < NW; k++) begin
      n_alloc  = n_alloc + TAG_W'(alloc_valid[k]);
      n_commit = n_commit + TAG_W'(commit_mask[k]);
      if (commit_mask[k]) commit_clr[head[IDX_W-1:0] + IDX_W'(k)] = 1'b1;
      if (alloc_fire && alloc_valid[k]) alloc_set[tail[IDX_W-1:0] + IDX_W'(k)] = 1'b1;
    end
  end

  rob_commit_sel #(.NW(NW), .CNT_W(TAG_W)) u_commit_sel (
    .enable      (commit_en),
    .avail       (commit_avail),
    .win_valid   (win_valid),
    .win_done    (win_done),
    .win_exc     (win_exc),
    .commit_mask (commit_mask),
    .head_exc    (head_exc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      ent_valid   <= '0;
      ent_done    <= '0;
      ent_exc     <= '0;
      flush_valid <= 1'b0;
      flush_pc    <= '0;
    end else if (!stop) begin
      flush_valid <= flush_take;
      if (flush_take) begin
        flush_pc  <= ent_pc[head[IDX_W-1:0]];
        ent_valid <= '0;
        head      <= tail;
      end else begin
        // Later ports overwrite earlier ones, so the highest-numbered port wins a tag collision.
        for (int p = 0; p < NWB; p++) begin
          if (wb_hit[p]) begin
            ent_done[wb_tag[p*TAG_W +: IDX_W]] <= 1'b1;
            ent_exc[wb_tag[p*TAG_W +: IDX_W]]  <= wb_exc[p];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (alloc_set[i]) begin
            ent_done[i] <= 1'b0;
            ent_exc[i]  <= 1'b0;
          end
        end
        ent_valid <= (ent_valid & ~commit_clr & ~squash) | alloc_set;
        head      <= head + n_commit;
        if (bp_hit) tail <= bp_next;
        else if (alloc_fire) tail <= tail + n_alloc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stop) begin
      for (int p = 0; p < NWB; p++) begin
        if (wb_hit[p]) ent_data[wb_tag[p*TAG_W +: IDX_W]] <= wb_data[p*DATA_W +: DATA_W];
      end
      for (int k = 0; k < NW; k++) begin
        if (alloc_fire && alloc_valid[k]) begin
          ent_pc[tail[IDX_W-1:0] + IDX_W'(k)] <= alloc_pc[k*PC_W +: PC_W];
          ent_rd[tail[IDX_W-1:0] + IDX_W'(k)] <= alloc_rd[k*PREG_W +: PREG_W];
        end
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, entry count (power of two, at least 8).
REQ-002 SHALL have parameter NW, default 4, allocate/commit lanes per cycle.
REQ-003 SHALL have parameter NWB, default 4, writeback ports.
REQ-004 SHALL have parameters DATA_W, PC_W and PREG_W, defaults 32, 64 and 8, giving result, PC and physical-register widths.
REQ-005 SHALL use derived widths IDX_W = log2(DEPTH) and TAG_W = IDX_W+1; the tag MSB is the wrap bit.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 stop  in  1  global freeze.
REQ-009 alloc_valid  in  NW  allocation request; lanes packed from lane 0.
REQ-010 alloc_pc / alloc_rd  in  NW*PC_W / NW*PREG_W  per-lane PC and destination register.
REQ-011 alloc_ready  out  1  allocation accepted this cycle.
REQ-012 alloc_tag  out  NW*TAG_W  tag assigned to each lane, equal to tail+lane.
REQ-013 wb_valid / wb_tag / wb_data / wb_exc  in  NWB / NWB*TAG_W / NWB*DATA_W / NWB  completion ports.
REQ-014 commit_valid  out  NW  thermometer mask of retiring lanes.
REQ-015 commit_tag / commit_pc / commit_rd / commit_data  out  per lane  fields of the retiring entry.
REQ-016 bp_mispredict / bp_tag  in  1 / TAG_W  squash every entry younger than bp_tag.
REQ-017 flush_valid / flush_pc  out  1 / PC_W  registered exception-flush pulse and faulting PC.
REQ-018 count / full / empty  out  IDX_W+1 / 1 / 1  occupancy status.

Function
REQ-019 head and tail SHALL be TAG_W-bit pointers; count = tail-head modulo 2^TAG_W; full = (count == DEPTH); empty = (count == 0).
REQ-020 alloc_ready SHALL be !stop && !bp_mispredict && !flush_valid && (DEPTH-count >= NW).
- Allocation is all-or-nothing.
- alloc_valid is ignored when alloc_ready is 0.
REQ-021 On accepted allocation, each valid lane i SHALL write entry tail+i with valid=1, done=0, exc=0; tail advances by popcount(alloc_valid).
REQ-022 A writeback SHALL set done=1, store data and exc only when:
- its tag lies in [head, tail) under wrap-bit comparison, and
- the target entry is valid.
Any other writeback is silently dropped.
REQ-023 When two writeback ports hit the same tag in one cycle, the higher-numbered port SHALL win.
REQ-024 Commit (combinational selection, state update on the edge):
- lane k is valid iff entries head..head+k are all valid, done and exc=0, and k < count;
- head advances by popcount(commit_valid) in the same edge.
REQ-025 A writeback SHALL NOT commit in the cycle it arrives; minimum writeback-to-commit latency is 1 cycle.
REQ-026 Exception at head: when the head entry is done with exc=1, and no flush is pending, the block SHALL:
- retire nothing that cycle;
- on the next edge, raise flush_valid for exactly one cycle with flush_pc = that entry's PC;
- invalidate all entries and set head = tail.
REQ-027 Mispredict: if bp_tag lies in [head, tail), on the edge the block SHALL:
- invalidate entries bp_tag+1 .. tail-1;
- set tail = bp_tag+1.
If bp_tag is outside that window, the mispredict is ignored.
REQ-028 Commit of older entries, up to and including bp_tag, SHALL proceed in the same cycle as a mispredict.
REQ-029 Priority order SHALL be exception flush > mispredict > allocation; writebacks are still applied in a mispredict cycle unless they target a squashed entry.
REQ-030 While stop=1:
- all state holds;
- commit_valid = 0 and alloc_ready = 0;
- a pending flush_valid pulse is delayed until stop deasserts.
REQ-031 Pointer wrap SHALL be seamless: tail passing index DEPTH-1 toggles the wrap bit, and full/empty remain correct.

Reset
REQ-032 Asserting reset SHALL immediately, mid-operation included, set:
- head = tail = 0 and all valid = 0;
- commit_valid = 0 and flush_valid = 0;
- count = 0, empty = 1, full = 0, alloc_ready = 1 (stop permitting).
REQ-033 No writeback, allocation or mispredict held across reset deassertion SHALL take effect before the first post-reset edge.

Structure
REQ-034 Package rob_pkg SHALL hold:
- default parameters;
- the entry typedef (valid, done, exc, pc, rd, data);
- the tag-in-window age-compare function.
The mispredict handler and the writeback filter share that function.
REQ-035 Sub-module rob_commit_sel SHALL compute the commit mask and the head-exception detect from the NW head-window entries.

Verification
REQ-036 The bench SHALL cover each of the following scenarios (with DEPTH=64, NW=4 where sizes matter):
- Allocate 4 per cycle for 16 cycles → full=1, alloc_ready=0, count=64; writeback all → 4 commits per cycle, empty after 16 cycles.
- Allocate tags 0-3, write back tag 2 then tag 0 → no commit after tag 2; after tag 0, commit_valid=0001; after tag 1 and 3, commit_valid=0111 on the next cycle.
- Tags 0-7 live, bp_mispredict with bp_tag=3 → tail=4, count=4, a later writeback to tag 5 is ignored, next allocation gets tag 4.
- Head tag 0 written back with wb_exc=1 and pc=0x1000 → flush_valid one cycle with flush_pc=0x1000, then empty=1 and head=tail.
- Run 70 allocate/commit cycles of 1 entry each → tag wraps from 63 to 64 (wrap bit set, index 0), and count and full stay correct throughout.
- Assert reset asynchronously mid-burst → outputs take their reset values before the next clk edge.
